// File: rtl/arbitro_pkg.sv
// Shared types and helpers for the round-robin / fixed-priority arbiter.
package arbitro_pkg;

  typedef enum {ARB_RR, ARB_FIXED} arb_mode_e;

  typedef enum logic {IDLE, GRANTED} arb_state_e;

  localparam int MAX_REQ = 32;

  // Index of the highest set bit of a one-hot vector (0 for an all-zero vector).
  function automatic int unsigned onehot2bin(input logic [MAX_REQ-1:0] oh);
    onehot2bin = 0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (oh[i]) onehot2bin = unsigned'(i);
    end
  endfunction

endpackage

// File: rtl/arbitro_rr_if.sv
// Requester-side bus of the arbiter: request vector in, grant/index/availability out.
interface arbitro_rr_if #(
  parameter int N_REQ = 4
);
  localparam int GNT_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] grant;
  logic [GNT_W-1:0] grant_num;
  logic             av;

  modport master (output req, input grant, grant_num, av);
  modport slave  (input req, output grant, grant_num, av);
endinterface

// File: rtl/arbitro_pick.sv
// Combinational masked picker: first set bit of (req & ~excl), searched
// upward from start with wrap-around (round-robin) or from index 0 (fixed).
module arbitro_pick
  import arbitro_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int GNT_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] excl,
  input  logic [GNT_W-1:0] start,
  input  arb_mode_e        mode,
  output logic             found,
  output logic [GNT_W-1:0] winner
);

  logic [N_REQ-1:0] masked;
  int               base;

  assign masked = req & ~excl;
  assign base   = (mode == ARB_FIXED) ? 0 : int'(start);

  // Scan candidates in priority order; the first eligible one wins.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!found && masked[(base + i) % N_REQ]) begin
        found  = 1'b1;
        winner = GNT_W'((base + i) % N_REQ);
      end
    end
  end

endmodule

// File: rtl/arbitro_rr.sv
// Registered arbiter for one shared resource: grant is held while the owner
// keeps requesting, up to MAX_HOLD cycles when others are waiting.
module arbitro_rr
  import arbitro_pkg::*;
#(
  parameter int        N_REQ    = 4,
  parameter arb_mode_e MODE     = ARB_RR,
  parameter int        MAX_HOLD = 8
) (
  input logic         clk,
  input logic         rst_n,
  arbitro_rr_if.slave bus
);

  localparam int GNT_W     = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int HOLD_W    = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam int HOLD_LAST = (MAX_HOLD > 0) ? MAX_HOLD - 1 : 0;

  arb_state_e       state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [GNT_W-1:0] num_q, num_d;
  logic [GNT_W-1:0] ptr_q, ptr_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic             av_q, av_d;

  logic [N_REQ-1:0] excl;
  logic             found;
  logic [GNT_W-1:0] winner;
  logic             owner_req;
  logic             expired;
  logic             handover;

  // The current owner is never a candidate for its own handover.
  assign excl      = (state_q == GRANTED) ? grant_q : '0;
  assign owner_req = |(bus.req & grant_q);
  assign expired   = (MAX_HOLD != 0) && (hold_q == HOLD_W'(HOLD_LAST));

  arbitro_pick #(
    .N_REQ (N_REQ),
    .GNT_W (GNT_W)
  ) u_pick (
    .req    (bus.req),
    .excl   (excl),
    .start  (ptr_q),
    .mode   (MODE),
    .found  (found),
    .winner (winner)
  );

  // Next-state: new grant, release to idle, hold-time preemption or stay.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    num_d    = num_q;
    ptr_d    = ptr_q;
    hold_d   = hold_q;
    handover = 1'b0;

    case (state_q)
      IDLE: begin
        if (found) handover = 1'b1;
      end
      GRANTED: begin
        if (!owner_req) begin
          if (found) begin
            handover = 1'b1;
          end else begin
            state_d = IDLE;
            grant_d = '0;
            hold_d  = '0;
          end
        end else if (expired && found) begin
          handover = 1'b1;
        end else if ((MAX_HOLD != 0) && !expired) begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
        hold_d  = '0;
      end
    endcase

    if (handover) begin
      state_d         = GRANTED;
      grant_d         = '0;
      grant_d[winner] = 1'b1;
      num_d           = winner;
      hold_d          = '0;
      ptr_d           = (int'(winner) == N_REQ - 1) ? '0 : winner + GNT_W'(1);
    end

    av_d = ~|grant_d;
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      num_q   <= '0;
      ptr_q   <= '0;
      hold_q  <= '0;
      av_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      num_q   <= num_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
      av_q    <= av_d;
    end
  end

  assign bus.grant     = grant_q;
  assign bus.grant_num = num_q;
  assign bus.av        = av_q;

endmodule

// File: tb/tb_arbitro_rr.sv
// Directed bench for arbitro_rr: a round-robin instance (MAX_HOLD=4) and a
// fixed-priority instance (MAX_HOLD=0), checked through a scoreboard queue.
module tb_arbitro_rr;
  import arbitro_pkg::*;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  arbitro_rr_if #(.N_REQ(4)) bus_rr ();
  arbitro_rr_if #(.N_REQ(4)) bus_fx ();

  arbitro_rr #(.N_REQ(4), .MODE(ARB_RR), .MAX_HOLD(4)) dut_rr (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_rr)
  );

  arbitro_rr #(.N_REQ(4), .MODE(ARB_FIXED), .MAX_HOLD(0)) dut_fx (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_fx)
  );

  typedef struct {
    string      name;
    bit         sel;
    logic [3:0] grant;
    logic [1:0] num;
    logic       av;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", nm, act, exp_v, $time);
    end
  endtask

  // Apply inputs on the falling edge; expectation is for the outputs after the next rising edge.
  task automatic step(input string nm, input bit sel, input logic rst, input logic [3:0] r,
                      input logic [3:0] g, input logic [1:0] n, input logic a);
    exp_t e;
    @(negedge clk);
    rst_n = rst;
    if (sel) begin
      bus_fx.req = r;
      bus_rr.req = '0;
    end else begin
      bus_rr.req = r;
      bus_fx.req = '0;
    end
    e.name  = nm;
    e.sel   = sel;
    e.grant = g;
    e.num   = n;
    e.av    = a;
    sb.push_back(e);
  endtask

  // Monitor: pop one expectation per cycle and compare, plus output invariants.
  initial begin
    exp_t       e;
    logic [3:0] g;
    logic [1:0] n;
    logic       a;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        g = e.sel ? bus_fx.grant     : bus_rr.grant;
        n = e.sel ? bus_fx.grant_num : bus_rr.grant_num;
        a = e.sel ? bus_fx.av        : bus_rr.av;
        chk({e.name, " grant"}, 32'(g), 32'(e.grant));
        chk({e.name, " grant_num"}, 32'(n), 32'(e.num));
        chk({e.name, " av"}, 32'(a), 32'(e.av));
        chk({e.name, " inv_av"}, 32'(a), 32'(~|g));
        chk({e.name, " inv_onehot"}, 32'($onehot0(g)), 32'd1);
        if (g != 4'b0000) chk({e.name, " inv_num"}, 32'(n), onehot2bin(32'(g)));
      end
    end
  end

  initial begin
    rst_n      = 1'b0;
    bus_rr.req = '0;
    bus_fx.req = '0;

    // reset with all requests active
    step("rst_a", 0, 0, 4'b1111, 4'b0000, 2'd0, 1'b1);
    step("rst_b", 0, 0, 4'b1111, 4'b0000, 2'd0, 1'b1);
    // rotation: each owner exactly 4 cycles, no idle cycle
    for (int k = 0; k < 16; k++)
      step("rot", 0, 1, 4'b1111, 4'b0001 << (k / 4), 2'(k / 4), 1'b0);
    step("rot_wrap", 0, 1, 4'b1111, 4'b0001, 2'd0, 1'b0);
    step("drop0", 0, 1, 4'b0000, 4'b0000, 2'd0, 1'b1);

    // single requester
    step("rst_c", 0, 0, 4'b0000, 4'b0000, 2'd0, 1'b1);
    step("one", 0, 1, 4'b0001, 4'b0001, 2'd0, 1'b0);
    step("one_drop", 0, 1, 4'b0000, 4'b0000, 2'd0, 1'b1);

    // release handover without bubble, and wrap via rr_ptr
    step("own1", 0, 1, 4'b0110, 4'b0010, 2'd1, 1'b0);
    step("hand2", 0, 1, 4'b0100, 4'b0100, 2'd2, 1'b0);
    step("own3", 0, 1, 4'b1001, 4'b1000, 2'd3, 1'b0);
    step("wrap_hand", 0, 1, 4'b0001, 4'b0001, 2'd0, 1'b0);

    // grant_num keeps last owner while idle
    step("own3b", 0, 1, 4'b1000, 4'b1000, 2'd3, 1'b0);
    step("idle_num", 0, 1, 4'b0000, 4'b0000, 2'd3, 1'b1);

    // release coinciding with hold expiry, then a one-cycle drop
    step("own0", 0, 1, 4'b0011, 4'b0001, 2'd0, 1'b0);
    for (int k = 0; k < 3; k++)
      step("hold0", 0, 1, 4'b0011, 4'b0001, 2'd0, 1'b0);
    step("rel_exp", 0, 1, 4'b0010, 4'b0010, 2'd1, 1'b0);
    step("blip", 0, 1, 4'b0000, 4'b0000, 2'd1, 1'b1);
    step("rereq", 0, 1, 4'b0010, 4'b0010, 2'd1, 1'b0);

    // reset in the middle of a grant also clears rr_ptr
    step("own2", 0, 1, 4'b0100, 4'b0100, 2'd2, 1'b0);
    step("rst_mid", 0, 0, 4'b0100, 4'b0000, 2'd0, 1'b1);
    step("after_rst", 0, 1, 4'b1100, 4'b0100, 2'd2, 1'b0);

    // fixed priority, unlimited hold
    step("fx_rst", 1, 0, 4'b0000, 4'b0000, 2'd0, 1'b1);
    step("fx_own1", 1, 1, 4'b1010, 4'b0010, 2'd1, 1'b0);
    for (int k = 0; k < 10; k++)
      step("fx_hold", 1, 1, 4'b1010, 4'b0010, 2'd1, 1'b0);
    for (int k = 0; k < 3; k++)
      step("fx_nopre", 1, 1, 4'b1011, 4'b0010, 2'd1, 1'b0);
    step("fx_rel", 1, 1, 4'b1001, 4'b0001, 2'd0, 1'b0);
    step("fx_idle", 1, 1, 4'b0000, 4'b0000, 2'd0, 1'b1);

    for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
    #2;
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d expectations left, required 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/arbitro_rr.md
Name: arbitro_rr

Overview:
- Parametrised, registered successor to the 4-input combinational arbiter `arbitro`.
- Arbitrates one shared resource among N_REQ requesters, in round-robin or fixed-priority mode.
- Holds a grant for as long as the owner keeps its request high, up to a bounded hold time.
- Reports a one-hot grant, its index and resource availability, like `arbitro`. Sits between requesting masters and the shared resource.

Parameters:
- N_REQ, 4, number of requesters (≥1).
- MODE, ARB_RR, arbitration policy: ARB_RR (round-robin) or ARB_FIXED (lowest index wins).
- MAX_HOLD, 8, max consecutive cycles one owner keeps the grant while others wait; 0 = unlimited.
- GNT_W, derived localparam, (N_REQ>1) ? $clog2(N_REQ) : 1.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- req  in  N_REQ  request vector; bit i high = requester i wants or keeps the resource.
- grant  out  N_REQ  registered one-hot grant; all zero when idle.
- grant_num  out  GNT_W  binary index of the owner; holds the last owner's index while idle.
- av  out  1  resource available; equals ~|grant, registered.

Behaviour:
- Clock and reset: one clock. Reset is synchronous, active-low, sampled on the rising clk edge.
- Reset values: grant=0, grant_num=0, av=1, state=IDLE, rr_ptr=0, hold_cnt=0. Reset dominates every other event, including mid-grant.
- States:
  - IDLE: no owner. If |req, pick a winner; next edge goes to GRANTED with grant=onehot(w), grant_num=w, av=0. Latency from req to grant is 1 cycle.
  - GRANTED: owner o.
    - Release: req[o]==0 in a cycle means release. If other req bits are set, pick a new winner that same cycle, excluding o; the new grant appears on the next edge with no idle bubble. Otherwise go to IDLE with grant=0, av=1.
    - Preempt: when hold_cnt==MAX_HOLD-1, MAX_HOLD!=0, and another req bit is set, pick a new winner excluding o; hand over on the next edge.
    - Stay: req[o]==1 and no preemption keeps the grant unchanged. hold_cnt increments, saturating at MAX_HOLD-1.
- hold_cnt clears to 0 on every new grant, including a handover.
- ARB_RR picking: search starts at rr_ptr, ascending, wrapping N_REQ-1 → 0. The first set bit wins. On each new grant, rr_ptr ← (w+1) mod N_REQ.
- ARB_FIXED picking: the lowest set index wins; the current owner is masked out on release or preempt. A higher-priority request arriving mid-grant does NOT preempt; only release or hold expiry ends a grant.
- Simultaneous events:
  - Owner drops req and MAX_HOLD expires in the same cycle: treated as release, same result.
  - Owner drops req for exactly one cycle: that is a release. It re-requests through normal arbitration.
- N_REQ=1: grant mirrors req delayed 1 cycle; preemption never fires (no other requester).
- grant is always one-hot or zero.
- Invariants for assertions: av==~|grant; grant_num matches grant whenever grant!=0.

Decomposition:
- Package `arbitro_pkg`:
  - typedef enum {ARB_RR, ARB_FIXED} arb_mode_e.
  - typedef enum logic {IDLE, GRANTED} arb_state_e.
  - function onehot2bin.
- Sub-module `arbitro_pick`: combinational masked picker.
  - Inputs: req, exclude mask, start pointer, mode.
  - Outputs: found, winner index.
  - Instantiated once. It is the generalised successor of the original combinational `arbitro`.

Test Plan (N_REQ=4, MAX_HOLD=4, ARB_RR unless noted):
- rst_n=0 for 2 cycles with req=4'b1111 → grant=0000, grant_num=0, av=1 throughout. Release reset → grant=0001 one cycle later.
- req=0001 from cycle 0 → cycle 1: grant=0001, grant_num=0, av=0. Drop req → next cycle grant=0000, av=1, grant_num=0.
- req=1111 held constant → owners 0,1,2,3,0 in turn, each held exactly 4 cycles, no cycle with av=1.
- Owner 1 with req=0110, then req→0100 → next cycle grant=0100, grant_num=2, no bubble. Then owner 3 with req=1001, req→0001 → grant=0001 (wrap via rr_ptr=0).
- ARB_FIXED, MAX_HOLD=0, req=1010 → grant=0010 and held. req0 rises mid-grant → grant unchanged. req1 falls → grant=0001.
- Reset mid-grant: owner 2 granted, rst_n=0 for one edge → grant=0000, av=1, rr_ptr=0. With req=1100 after release → grant=0100.
